// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial add/subtract controller.
package nibble_serial_addsub_ctrl_pkg;

  // Width of the single shared arithmetic slice.
  localparam int NIBBLE_W = 4;

  // Controller states; the unused code 2'd3 is decoded as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width, kept at least one bit even for a single nibble.
  function automatic int idx_width(input int nibbles);
    return $clog2(nibbles > 1 ? nibbles : 2);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_slice.sv
// Combinational 4-bit add/subtract slice: ripple of four full-adder cells on a and b^m.
// Exposes the carry into bit 3 so the controller can form signed overflow.
module addsub_nibble_slice
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                c4
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W:0]   c;

  // Ripple the carry through four full-adder cells, b optionally inverted for subtract.
  always_comb begin
    bx   = b ^ {NIBBLE_W{m}};
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign c3 = c[NIBBLE_W-1];
  assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial W-bit add/subtract controller. One shared 4-bit slice is stepped over
// the operands LS nibble first with a registered inter-nibble carry; valid/ready on
// both the operand and result sides, no overlap between operations.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        sub,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        carry_out,
  output logic                        overflow,
  output logic                        busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             sub_reg;

  logic             load;
  logic             step;
  logic             last_nib;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c3;
  logic                slice_c4;

  assign last_nib = (idx == IDX_W'(NIBBLES - 1));
  assign slice_a  = a_reg[NIBBLE_W*idx +: NIBBLE_W];
  assign slice_b  = b_reg[NIBBLE_W*idx +: NIBBLE_W];

  addsub_nibble_slice u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .m   (sub_reg),
    .cin (carry_reg),
    .s   (slice_s),
    .c3  (slice_c3),
    .c4  (slice_c4)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; the unused encoding behaves as IDLE.
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_nib) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        start_ready = 1'b1;
        if (start_valid) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
    endcase
  end

  // Operand capture, per-nibble accumulation and final flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      a_reg     <= a;
      b_reg     <= b;
      sub_reg   <= sub;
      carry_reg <= sub;
      idx       <= '0;
      result    <= '0;
    end else if (step) begin
      result[NIBBLE_W*idx +: NIBBLE_W] <= slice_s;
      carry_reg <= slice_c4;
      if (last_nib) begin
        idx       <= '0;
        carry_out <= slice_c4;
        overflow  <= slice_c3 ^ slice_c4;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
